driver_safety_escalator: RTL and testbench

Parametrised, multi-channel successor to the driver-monitor safety state machine. It runs one escalation FSM per monitored channel, each fed by its own averaged drowsiness/distraction score, against shared warning and emergency thresholds. Compared with the single-channel FSM, it adds three things: persistence filtering, so one-cycle spikes do not escalate; hysteresis on de-escalation; and an acknowledge-based exit from the latched emergency. It sits between the per-channel score averagers and the alert and actuator logic.

---
 rtl/driver_safety_escalator_if.sv | 52 +++++
 rtl/driver_safety_escalator.sv | 193 +++++++++++++++++++
 tb/tb_driver_safety_escalator.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/driver_safety_escalator_if.sv
// -----------------------------------------------------------------------------
// driver_safety_escalator_if
//
// Purpose : bundles the score/threshold inputs and the alert outputs of the
//           multi-channel driver safety escalator.
//
// Parameters
//   N_CH : number of score channels
//   W    : score / threshold width in bits
//
// Signals
//   avg_sc        N_CH*W  packed per-channel averaged scores, ch i at [i*W +: W]
//   warn_th       W       shared warning threshold
//   emer_th       W       shared emergency threshold
//   ack           N_CH    per-channel emergency acknowledge (level)
//   warning       N_CH    channel is in WARN
//   emergency     N_CH    channel is in EMER or LATCH
//   emer_evt      N_CH    one-cycle pulse on EMER entry
//   any_warning   1       OR of warning
//   any_emergency 1       OR of emergency
//   emer_count    8       saturating count of emer_evt pulses
//
// Modports
//   master : score source / alert consumer side (drives scores, thresholds, ack)
//   slave  : the escalator itself
// -----------------------------------------------------------------------------
interface driver_safety_escalator_if #(
    parameter int N_CH = 2,
    parameter int W    = 8
);
    logic [N_CH*W-1:0] avg_sc;
    logic [W-1:0]      warn_th;
    logic [W-1:0]      emer_th;
    logic [N_CH-1:0]   ack;

    logic [N_CH-1:0]   warning;
    logic [N_CH-1:0]   emergency;
    logic [N_CH-1:0]   emer_evt;
    logic              any_warning;
    logic              any_emergency;
    logic [7:0]        emer_count;

    modport master (
        output avg_sc, warn_th, emer_th, ack,
        input  warning, emergency, emer_evt, any_warning, any_emergency, emer_count
    );

    modport slave (
        input  avg_sc, warn_th, emer_th, ack,
        output warning, emergency, emer_evt, any_warning, any_emergency, emer_count
    );
endinterface

// File: rtl/driver_safety_escalator.sv
// -----------------------------------------------------------------------------
// driver_safety_escalator
//
// Purpose : one escalation FSM per monitored channel (SAFE -> WARN -> EMER ->
//           LATCH) driven by that channel's averaged drowsiness/distraction
//           score against shared thresholds. Escalation is persistence
//           filtered, de-escalation from WARN uses a hysteresis floor, and the
//           latched emergency is left only on acknowledge with a low score.
//           All alert outputs are Moore decodes of registered state.
//
// Parameters
//   N_CH    : number of channels (>= 1); must match the interface instance
//   W       : score / threshold width; must match the interface instance
//   PERSIST : consecutive cycles a condition must hold before escalating (>= 1)
//   HYST    : margin below warn_th required to fall back to SAFE
//
// Ports
//   clk : clock, all logic on the rising edge
//   rst : synchronous, active-high reset
//   bus : driver_safety_escalator_if.slave (scores, thresholds, ack, alerts)
// -----------------------------------------------------------------------------
module driver_safety_escalator #(
    parameter int N_CH    = 2,
    parameter int W       = 8,
    parameter int PERSIST = 3,
    parameter int HYST    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    driver_safety_escalator_if.slave    bus
);

    typedef enum logic [1:0] {
        SAFE  = 2'd0,
        WARN  = 2'd1,
        EMER  = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Persistence counter: holds 0 .. PERSIST-1 while a condition is pending.
    localparam int             CW       = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PERSIST - 1);

    // Popcount / saturating-sum widths for the event counter.
    localparam int             PCW      = $clog2(N_CH + 1);
    localparam int             SW       = 9 + PCW;
    localparam logic [SW-1:0]  CNT_MAX  = SW'(255);

    localparam logic [W:0]     HYST_W   = (W + 1)'(HYST);

    state_t          state_q [N_CH];
    state_t          state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [W-1:0]    score   [N_CH];
    logic [W-1:0]    lo_th;

    logic [N_CH-1:0] warning_v;
    logic [N_CH-1:0] emergency_v;
    logic [N_CH-1:0] emer_evt_v;
    logic [PCW-1:0]  evt_pop;
    logic [SW-1:0]   count_sum;
    logic [7:0]      emer_count_q;

    // Unpack per-channel scores.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            score[i] = bus.avg_sc[i*W +: W];
        end
    end

    // Hysteresis floor; clamps at 0 instead of wrapping when warn_th < HYST.
    always_comb begin
        if ({1'b0, bus.warn_th} < HYST_W) begin
            lo_th = '0;
        end else begin
            lo_th = bus.warn_th - HYST_W[W-1:0];
        end
    end

    // Next-state logic for every channel.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: every variable gets a default before the case so no path
            // leaves it unassigned, which would otherwise infer a latch.
            // The counter defaults to 0, which also covers "clear on any state
            // change" and "held at 0 in EMER/LATCH".
            state_d[i] = state_q[i];
            cnt_d[i]   = '0;

            unique case (state_q[i])
                SAFE: begin
                    if (score[i] > bus.warn_th) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = WARN;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end

                WARN: begin
                    // Emergency check wins over de-escalation, even when
                    // emer_th is misconfigured below warn_th.
                    if (score[i] > bus.emer_th) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            state_d[i] = EMER;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end else if (score[i] <= lo_th) begin
                        state_d[i] = SAFE;
                    end
                end

                EMER: begin
                    state_d[i] = LATCH;
                end

                LATCH: begin
                    // ack with a score still above the floor is simply dropped.
                    if (bus.ack[i] && (score[i] <= lo_th)) begin
                        state_d[i] = SAFE;
                    end
                end

                default: begin
                    state_d[i] = SAFE;
                end
            endcase
        end
    end

    // State and persistence counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= SAFE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Moore output decode from registered state only.
    always_comb begin
        warning_v   = '0;
        emergency_v = '0;
        emer_evt_v  = '0;
        for (int i = 0; i < N_CH; i++) begin
            warning_v[i]   = (state_q[i] == WARN);
            emergency_v[i] = (state_q[i] == EMER) || (state_q[i] == LATCH);
            emer_evt_v[i]  = (state_q[i] == EMER);
        end
    end

    // Number of channels pulsing emer_evt this cycle.
    always_comb begin
        evt_pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            evt_pop = evt_pop + PCW'(emer_evt_v[i]);
        end
    end

    assign count_sum = SW'(emer_count_q) + SW'(evt_pop);

    // Saturating event counter: accumulates the pulses visible this cycle, so
    // it reflects an event on the edge that ends the emer_evt cycle. A reset
    // in that cycle clears it, dropping the pending event.
    always_ff @(posedge clk) begin
        if (rst) begin
            emer_count_q <= '0;
        end else if (count_sum > CNT_MAX) begin
            emer_count_q <= 8'hFF;
        end else begin
            emer_count_q <= count_sum[7:0];
        end
    end

    assign bus.warning       = warning_v;
    assign bus.emergency     = emergency_v;
    assign bus.emer_evt      = emer_evt_v;
    assign bus.any_warning   = |warning_v;
    assign bus.any_emergency = |emergency_v;
    assign bus.emer_count    = emer_count_q;

endmodule

// File: tb/tb_driver_safety_escalator.sv
// -----------------------------------------------------------------------------
// tb_driver_safety_escalator
//
// Purpose : self-checking bench for driver_safety_escalator (N_CH=2, W=8,
//           PERSIST=3, HYST=4). Stimulus drives inputs on the falling edge and
//           pushes the reference model's expected post-edge outputs into a
//           queue; an independent monitor pops one entry per rising edge and
//           compares it against the DUT.
// -----------------------------------------------------------------------------
module tb_driver_safety_escalator;

    localparam int N_CH    = 2;
    localparam int W       = 8;
    localparam int PERSIST = 3;
    localparam int HYST    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    driver_safety_escalator_if #(.N_CH(N_CH), .W(W)) bus ();

    driver_safety_escalator #(
        .N_CH   (N_CH),
        .W      (W),
        .PERSIST(PERSIST),
        .HYST   (HYST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [N_CH-1:0] warning;
        logic [N_CH-1:0] emergency;
        logic [N_CH-1:0] emer_evt;
        logic            any_warning;
        logic            any_emergency;
        logic [7:0]      emer_count;
    } exp_t;

    exp_t exp_q [$];

    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------------------------
    // Reference model. Each channel is described by its alarm level and how
    // many consecutive qualifying samples it has seen in a row.
    // ---------------------------------------------------------------------
    localparam int CALM   = 0;  // no alert
    localparam int ALERT  = 1;  // warning raised
    localparam int FIRING = 2;  // emergency just declared (event cycle)
    localparam int HELD   = 3;  // emergency held until acknowledged

    int level  [N_CH];
    int streak [N_CH];
    int m_count;

    int wth = 100;
    int eth = 200;

    task automatic model_step(input int sc0, input int sc1, input logic [1:0] a, input logic r);
        int   sc [N_CH];
        int   lo;
        int   fired;
        exp_t e;
        sc[0] = sc0;
        sc[1] = sc1;
        lo    = (wth >= HYST) ? (wth - HYST) : 0;
        if (r) begin
            for (int c = 0; c < N_CH; c++) begin
                level[c]  = CALM;
                streak[c] = 0;
            end
            m_count = 0;
        end else begin
            fired = 0;
            for (int c = 0; c < N_CH; c++) if (level[c] == FIRING) fired++;
            m_count = (m_count + fired > 255) ? 255 : m_count + fired;
            for (int c = 0; c < N_CH; c++) begin
                if (level[c] == CALM) begin
                    streak[c] = (sc[c] > wth) ? streak[c] + 1 : 0;
                    if (streak[c] >= PERSIST) begin
                        level[c]  = ALERT;
                        streak[c] = 0;
                    end
                end else if (level[c] == ALERT) begin
                    if (sc[c] > eth) begin
                        streak[c]++;
                        if (streak[c] >= PERSIST) begin
                            level[c]  = FIRING;
                            streak[c] = 0;
                        end
                    end else begin
                        streak[c] = 0;
                        if (sc[c] <= lo) level[c] = CALM;
                    end
                end else if (level[c] == FIRING) begin
                    level[c] = HELD;
                end else begin
                    if (a[c] && sc[c] <= lo) level[c] = CALM;
                end
            end
        end
        e = '0;
        for (int c = 0; c < N_CH; c++) begin
            e.warning[c]   = (level[c] == ALERT);
            e.emergency[c] = (level[c] == FIRING) || (level[c] == HELD);
            e.emer_evt[c]  = (level[c] == FIRING);
        end
        e.any_warning   = |e.warning;
        e.any_emergency = |e.emergency;
        e.emer_count    = 8'(m_count);
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: drive on the falling edge, record expectation.
    task automatic step(input int sc0, input int sc1, input logic [1:0] a, input logic r);
        @(negedge clk);
        bus.avg_sc  = {W'(sc1), W'(sc0)};
        bus.ack     = a;
        bus.warn_th = W'(wth);
        bus.emer_th = W'(eth);
        rst         = r;
        model_step(sc0, sc1, a, r);
    endtask

    task automatic run(input int sc0, input int sc1, input logic [1:0] a, input int n);
        for (int k = 0; k < n; k++) step(sc0, sc1, a, 1'b0);
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: one comparison set per rising edge that has a pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("warning",       int'(bus.warning),       int'(e.warning));
                check("emergency",     int'(bus.emergency),     int'(e.emergency));
                check("emer_evt",      int'(bus.emer_evt),      int'(e.emer_evt));
                check("any_warning",   int'(bus.any_warning),   int'(e.any_warning));
                check("any_emergency", int'(bus.any_emergency), int'(e.any_emergency));
                check("emer_count",    int'(bus.emer_count),    int'(e.emer_count));
            end
        end
    end

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction

    function automatic int pick_score();
        int lo;
        lo = (wth >= HYST) ? (wth - HYST) : 0;
        case ($urandom_range(0, 8))
            0:       return 0;
            1:       return clamp(lo);
            2:       return clamp(lo + 1);
            3:       return clamp(wth);
            4:       return clamp(wth + 1);
            5:       return clamp(eth);
            6:       return clamp(eth + 1);
            7:       return 255;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        int s0;
        int s1;
        int guard;
        logic [1:0] a;

        bus.avg_sc  = '0;
        bus.ack     = '0;
        bus.warn_th = W'(wth);
        bus.emer_th = W'(eth);
        for (int c = 0; c < N_CH; c++) begin
            level[c]  = CALM;
            streak[c] = 0;
        end
        m_count = 0;

        // Reset
        step(0, 0, 2'b00, 1'b1);
        step(0, 0, 2'b00, 1'b1);

        // Persistence filter: one low sample restarts the count
        step(101, 0, 2'b00, 1'b0);
        step(101, 0, 2'b00, 1'b0);
        step(99,  0, 2'b00, 1'b0);
        run(101, 0, 2'b00, 3);

        // Hysteresis: 97 holds WARN, 96 drops to SAFE
        run(97, 0, 2'b00, 5);
        run(96, 0, 2'b00, 2);

        // Escalate, latch, ignored ack, valid ack
        run(101, 0, 2'b00, 3);
        run(201, 0, 2'b00, 3);
        run(201, 0, 2'b00, 1);
        run(50,  0, 2'b00, 3);
        run(150, 0, 2'b01, 2);
        run(96,  0, 2'b01, 1);
        run(0,   0, 2'b00, 2);

        // Reset while latched, then reset on the edge that would enter EMER
        run(101, 0, 2'b00, 3);
        run(201, 0, 2'b00, 5);
        step(201, 0, 2'b00, 1'b1);
        step(201, 0, 2'b00, 1'b1);
        run(0, 0, 2'b00, 3);
        run(101, 0, 2'b00, 3);
        run(201, 0, 2'b00, 2);
        step(201, 0, 2'b00, 1'b1);
        run(0, 0, 2'b00, 3);

        // Low warn_th: floor saturates to 0
        wth = 2;
        run(3, 0, 2'b00, 3);
        run(1, 0, 2'b00, 3);
        run(0, 0, 2'b00, 2);
        wth = 100;
        run(0, 0, 2'b00, 1);

        // Simultaneous double events up to saturation
        guard = 0;
        while (m_count < 254 && guard < 200) begin
            run(101, 101, 2'b00, 3);
            run(201, 201, 2'b00, 4);
            run(0,   0,   2'b11, 1);
            run(0,   0,   2'b00, 1);
            guard++;
        end
        run(101, 101, 2'b00, 3);
        run(201, 201, 2'b00, 4);
        run(0,   0,   2'b11, 2);

        // Randomised phase with sticky scores and occasional threshold changes
        s0 = 0;
        s1 = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                case ($urandom_range(0, 3))
                    0: begin wth = 100; eth = 200; end
                    1: begin wth = 2;   eth = int'($urandom_range(3, 255)); end
                    2: begin wth = int'($urandom_range(0, 255)); eth = int'($urandom_range(0, 255)); end
                    default: begin wth = 150; eth = 120; end
                endcase
            end
            if ($urandom_range(0, 3) == 0) s0 = pick_score();
            if ($urandom_range(0, 3) == 0) s1 = pick_score();
            a = 2'($urandom_range(0, 3));
            step(s0, s1, a, ($urandom_range(0, 199) == 0));
        end
        run(0, 0, 2'b00, 2);

        // Drain with a bounded wait
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
